wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle sequencer that performs WORDS*DW-bit add/subtract by time-sharing one
//  external DW-bit carry_bypass_adder, one limb per cycle, LS limb first, carry chained.
//  Valid/ready on operand input and result output; sits between the ALU issue logic
//  and the shared adder instance.
// PARAMETERS
//  DW     32  limb width; must equal the width of the attached adder
//  WORDS  4   limbs per operand (>=2); operand width = DW*WORDS
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous reset, active low
//  in_valid      in   1         operands/op presented
//  in_ready      out  1         sequencer can accept operands
//  in_a          in   DW*WORDS  operand A
//  in_b          in   DW*WORDS  operand B
//  in_sub        in   1         1: A-B (A+~B+1); 0: A+B+in_cin
//  in_cin        in   1         carry-in for add; ignored when in_sub=1
//  add_a         out  DW        limb A to adder
//  add_b         out  DW        limb B (already inverted for sub) to adder
//  add_cin       out  1         carry into current limb
//  add_sum       in   DW        adder sum (combinational from add_a/add_b/add_cin)
//  add_cout      in   1         adder carry-out
//  add_overflow  in   1         adder signed overflow
//  out_valid     out  1         result available
//  out_ready     in   1         consumer takes result
//  out_sum       out  DW*WORDS  result
//  out_cout      out  1         carry-out of MS limb (sub: 1 = no borrow)
//  out_overflow  out  1         signed overflow of full-width op (from MS limb)
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after limb WORDS-1;
//   DONE -> IDLE on out_valid&&out_ready. No other transitions.
//  in_ready = (state==IDLE); busy = !in_ready; out_valid = (state==DONE).
//  Accept: register in_a, (in_sub ? ~in_b : in_b), carry = in_sub ? 1 : in_cin;
//   idx <= 0; out_sum/out_cout/out_overflow cleared.
//  RUN, each cycle: add_a = a_reg[idx*DW +: DW], add_b = b_reg[idx*DW +: DW],
//   add_cin = carry (combinational from registers). At edge: out_sum limb idx <= add_sum,
//   carry <= add_cout, idx <= idx+1. On idx==WORDS-1 also out_cout <= add_cout,
//   out_overflow <= add_overflow, idx <= 0, -> DONE.
//  IDLE/DONE: add_a, add_b, add_cin driven 0.
//  Latency: accept at edge k -> out_valid high after edge k+WORDS. Min spacing between
//   accepts WORDS+2 cycles (RUN WORDS, DONE >=1, IDLE 1).
//  DONE: out_sum/out_cout/out_overflow held stable while out_valid && !out_ready;
//   in_valid ignored (in_ready=0) in RUN and DONE; operands need not be held after accept.
//  Results stay readable after DONE->IDLE until next accept.
//  Reset (async assert, any state): state=IDLE, idx=0, carry=0, all regs 0;
//   outputs: in_ready=1 (after rst_n high), out_valid=0, busy=0, out_sum=0, out_cout=0,
//   out_overflow=0, add_*=0. In-flight op discarded, no partial result emitted.
//  idx width = clog2(WORDS); idx never exceeds WORDS-1.
// TESTING (WORDS=4, DW=32, real carry_bypass_adder attached)
//  1 add A=128'hFFFF..FF, B=1, cin=0 -> out_sum=0, out_cout=1, out_overflow=0,
//    out_valid 4 cycles after accept edge.
//  2 sub A=5, B=7 -> out_sum=128'hFFFF..FFFE, out_cout=0, out_overflow=0.
//  3 add A=128'h7FFF..FF, B=1 -> out_sum=128'h8000_0000_0..0, out_overflow=1, out_cout=0;
//    carry crosses all limb boundaries.
//  4 out_ready low 10 cycles in DONE, in_valid held high -> out_valid/out_sum stable,
//    in_ready=0, second op not accepted until handshake + IDLE cycle.
//  5 rst_n low 2 cycles into RUN -> out_valid=0, busy=0 immediately; after release
//    in_ready=1 and next op (A=3,B=4 add) gives out_sum=7.
//  6 in_valid and out_ready tied high, random A/B/sub for 1000 ops -> accepts every 6
//    cycles; each result matches 128-bit reference model incl. cout/overflow.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Performs a DW*WORDS-bit add or subtract by time-sharing one external DW-bit
//   adder. One limb is processed per cycle, starting with the least significant
//   limb, and the carry is chained from one limb to the next. Operands come in
//   over a valid/ready handshake, and the result goes out over a second one.
//
// Ports
//   clk, rst_n                 clock (rising edge) and async active-low reset
//   in_valid/in_ready          operand handshake; in_ready is high only in IDLE
//   in_a, in_b                 operands (DW*WORDS bits)
//   in_sub                     1: A-B (A + ~B + 1), 0: A+B+in_cin
//   in_cin                     carry-in for add, ignored for subtract
//   add_a/add_b/add_cin        current limb and carry sent to the external adder
//   add_sum/add_cout/add_overflow  combinational response from the adder
//   out_valid/out_ready        result handshake; out_valid is high only in DONE
//   out_sum/out_cout/out_overflow  full-width result, carry of the MS limb and
//                                  signed overflow of the MS limb
//   busy                       high whenever the sequencer is not IDLE
module wide_add_sequencer #(
  parameter int DW    = 32,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*WORDS-1:0] in_a,
  input  logic [DW*WORDS-1:0] in_b,
  input  logic                in_sub,
  input  logic                in_cin,
  output logic [DW-1:0]       add_a,
  output logic [DW-1:0]       add_b,
  output logic                add_cin,
  input  logic [DW-1:0]       add_sum,
  input  logic                add_cout,
  input  logic                add_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_overflow,
  output logic                busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW = DW * WORDS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [TW-1:0]   r_a;
  logic [TW-1:0]   r_b;
  logic [TW-1:0]   r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            w_accept;
  logic            w_last;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_idx == IW'(WORDS - 1));

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Limb presented to the shared adder; the adder sees zeros outside RUN
  always_comb begin
    add_a   = {DW{1'b0}};
    add_b   = {DW{1'b0}};
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[r_idx*DW +: DW];
      add_b   = r_b[r_idx*DW +: DW];
      add_cin = r_carry;
    end else begin
      add_a   = {DW{1'b0}};
      add_b   = {DW{1'b0}};
      add_cin = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, limb sequencing and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= {IW{1'b0}};
      r_carry <= 1'b0;
      r_a     <= {TW{1'b0}};
      r_b     <= {TW{1'b0}};
      r_sum   <= {TW{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is folded into an add: B is inverted once here and the
      // +1 enters as the carry into limb 0.
      r_a     <= in_a;
      r_b     <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_idx   <= {IW{1'b0}};
      r_sum   <= {TW{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[r_idx*DW +: DW] <= add_sum;
      r_carry               <= add_cout;
      if (w_last) begin
        r_cout <= add_cout;
        r_ovf  <= add_overflow;
        r_idx  <= {IW{1'b0}};
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end else begin
      // DONE and idle without accept: keep the last result readable
      r_idx <= r_idx;
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_sum      = r_sum;
  assign out_cout     = r_cout;
  assign out_overflow = r_ovf;

endmodule
